// File: rtl/xd_pkg.sv
// Shared types and constants for the x*D skip-term scheduler.
package xd_pkg;

    localparam int unsigned DW = 16;

    // $clog2 that never returns 0, so single-entry dimensions still get a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = clog2_min1(1 * 24 * 64);
    localparam int unsigned H_W   = clog2_min1(24);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} xd_state_e;

endpackage

// File: rtl/xd_sched_if.sv
// Buffer-read, multiplier and result-stream signals of the x*D scheduler.
interface xd_sched_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned IDX_W = 11,
    parameter int unsigned H_W   = 5
);
    logic             x_ren_o;
    logic [IDX_W-1:0] x_addr_o;
    logic [DW-1:0]    x_rdata_i;
    logic             d_ren_o;
    logic [H_W-1:0]   d_addr_o;
    logic [DW-1:0]    d_rdata_i;
    logic             mul_valid_o;
    logic [DW-1:0]    mul_a_o;
    logic [DW-1:0]    mul_b_o;
    logic             mul_valid_i;
    logic [DW-1:0]    mul_res_i;
    logic             y_valid_o;
    logic [DW-1:0]    y_data_o;
    logic [IDX_W-1:0] y_addr_o;
    logic             y_ready_i;

    modport master (
        output x_ren_o, x_addr_o, d_ren_o, d_addr_o, mul_valid_o, mul_a_o, mul_b_o,
        output y_valid_o, y_data_o, y_addr_o,
        input  x_rdata_i, d_rdata_i, mul_valid_i, mul_res_i, y_ready_i
    );

    modport slave (
        input  x_ren_o, x_addr_o, d_ren_o, d_addr_o, mul_valid_o, mul_a_o, mul_b_o,
        input  y_valid_o, y_data_o, y_addr_o,
        output x_rdata_i, d_rdata_i, mul_valid_i, mul_res_i, y_ready_i
    );
endinterface

// File: rtl/xd_res_fifo.sv
// Synchronous first-word-fall-through result FIFO with occupancy count.
module xd_res_fifo
    import xd_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push_i,
    input  logic [Width-1:0]                    wdata_i,
    input  logic                                pop_i,
    output logic [Width-1:0]                    rdata_o,
    output logic                                valid_o,
    output logic [clog2_min1(Depth+1)-1:0]      count_o
);
    localparam int unsigned PtrW = clog2_min1(Depth);
    localparam int unsigned CntW = clog2_min1(Depth + 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        if (push_i) wr_d = (wr_q == PtrMax) ? '0 : wr_q + PtrW'(1);
        if (pop_i)  rd_d = (rd_q == PtrMax) ? '0 : rd_q + PtrW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[wr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem[rd_q] : '0;
    assign count_o = count_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) push_i |-> (count_q < CntW'(Depth)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop_i |-> valid_o);

endmodule

// File: rtl/xd_sched.sv
// Walks every (b,h,p) element once, feeds x[idx]*D[h] to the multiplier, returns tagged results.
module xd_sched
    import xd_pkg::*;
#(
    parameter int unsigned B        = 1,
    parameter int unsigned H        = 24,
    parameter int unsigned P        = 64,
    parameter int unsigned MUL_LAT  = 6,
    parameter int unsigned FIFO_DEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    xd_sched_if.master bus
);
    localparam int unsigned IdxW = clog2_min1(B * H * P);
    localparam int unsigned BW   = clog2_min1(B);
    localparam int unsigned HW   = clog2_min1(H);
    localparam int unsigned PW   = clog2_min1(P);
    localparam int unsigned CntW = clog2_min1(FIFO_DEP + 1);
    localparam int unsigned FlW  = clog2_min1(MUL_LAT + 2);
    localparam logic [BW-1:0] BMax = BW'(B - 1);
    localparam logic [HW-1:0] HMax = HW'(H - 1);
    localparam logic [PW-1:0] PMax = PW'(P - 1);

    xd_state_e        state_q, state_d;
    logic [BW-1:0]    b_q, b_d;
    logic [HW-1:0]    h_q, h_d;
    logic [PW-1:0]    p_q, p_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CntW-1:0]  inflight_q, inflight_d;
    logic [MUL_LAT:0] tag_vld_q;
    logic [IdxW-1:0]  tag_idx_q [MUL_LAT+1];
    logic [FlW-1:0]   flush_q;
    logic [CntW-1:0]  fifo_cnt;
    logic [CntW:0]    occ;
    logic             fifo_valid, issue, last, push, pop, has_credit;
    logic [DW+IdxW-1:0] fifo_rdata;

    assign last = (b_q == BMax) && (h_q == HMax) && (p_q == PMax);
    assign pop  = fifo_valid & bus.y_ready_i;
    assign push = tag_vld_q[MUL_LAT] & bus.mul_valid_i;
    // A slot freed by this cycle's pop may be claimed by this cycle's issue.
    assign occ        = (CntW+1)'(fifo_cnt) + (CntW+1)'(inflight_q);
    assign has_credit = occ < ((CntW+1)'(FIFO_DEP) + (CntW+1)'(pop));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    issue   = has_credit;
                    state_d = (issue && last) ? DRAIN : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                issue  = has_credit;
                if (issue && last) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (inflight_q == '0 && (fifo_cnt == '0 || (fifo_cnt == CntW'(1) && pop)))
                    state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        b_d        = b_q;
        h_d        = h_q;
        p_d        = p_q;
        idx_d      = idx_q;
        inflight_d = inflight_q + CntW'(issue) - CntW'(push);
        if (issue) begin
            idx_d = last ? '0 : idx_q + IdxW'(1);
            if (p_q == PMax) begin
                p_d = '0;
                if (h_q == HMax) begin
                    h_d = '0;
                    b_d = (b_q == BMax) ? '0 : b_q + BW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            b_q        <= '0;
            h_q        <= '0;
            p_q        <= '0;
            idx_q      <= '0;
            inflight_q <= '0;
            tag_vld_q  <= '0;
            flush_q    <= FlW'(MUL_LAT + 1);
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            h_q        <= h_d;
            p_q        <= p_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            tag_vld_q  <= {tag_vld_q[MUL_LAT-1:0], issue};
            if (flush_q != '0) flush_q <= flush_q - FlW'(1);
        end
    end

    always_ff @(posedge clk) begin
        tag_idx_q[0] <= idx_q;
        for (int i = 1; i <= MUL_LAT; i++) tag_idx_q[i] <= tag_idx_q[i-1];
    end

    xd_res_fifo #(
        .Width (DW + IdxW),
        .Depth (FIFO_DEP)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({tag_idx_q[MUL_LAT], bus.mul_res_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign bus.x_ren_o     = issue;
    assign bus.d_ren_o     = issue;
    assign bus.x_addr_o    = idx_q;
    assign bus.d_addr_o    = h_q;
    assign bus.mul_valid_o = tag_vld_q[0];
    assign bus.mul_a_o     = bus.x_rdata_i;
    assign bus.mul_b_o     = bus.d_rdata_i;
    assign bus.y_valid_o   = fifo_valid;
    assign bus.y_data_o    = fifo_rdata[DW-1:0];
    assign bus.y_addr_o    = fifo_rdata[DW+IdxW-1:DW];

    // Stray multiplier outputs just after reset belong to an aborted pass.
    a_tag_match: assert property (@(posedge clk) disable iff (rst)
        (flush_q == '0) |-> (bus.mul_valid_i == tag_vld_q[MUL_LAT]));

endmodule

// File: tb/tb_xd_sched.sv
// Randomized self-checking bench for xd_sched with buffer and multiplier models.
module tb_xd_sched;
    import xd_pkg::*;

    localparam int unsigned B = 1, H = 2, P = 4, N = B * H * P;
    localparam int unsigned MUL_LAT = 6, FIFO_DEP = 8;
    localparam int unsigned IW = clog2_min1(N);
    localparam int unsigned HWW = clog2_min1(H);

    logic clk = 1'b0, rst = 1'b1, start_i = 1'b0;
    logic busy_o, done_o;
    always #5 clk = ~clk;

    xd_sched_if #(.DW(16), .IDX_W(IW), .H_W(HWW)) bus ();

    xd_sched #(
        .B (B), .H (H), .P (P), .MUL_LAT (MUL_LAT), .FIFO_DEP (FIFO_DEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    logic [15:0] xmem [N];
    logic [15:0] dmem [H];
    logic [MUL_LAT-1:0] mv = '0;
    logic [15:0] mr [MUL_LAT];

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, first_vld_cyc = 0, last_pop_cyc = 0;
    int pops = 0, iss_cnt = 0, done_cnt = 0, exp_pop = 0, exp_iss = 0;
    bit first_seen = 0, hold = 0;
    logic [15:0] hold_data;
    logic [IW-1:0] hold_addr;

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int e;
        logic [21:0] m;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        if (m[21]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 31) return {s, 5'h1f, 10'd0};
        if (e <= 0) return {s, 15'd0};
        return {s, e[4:0], m[19:10]};
    endfunction

    function automatic logic [15:0] exp_y(input int i);
        return fp_mul(xmem[i], dmem[(i / P) % H]);
    endfunction

    function automatic logic [15:0] rnd_fp();
        logic [31:0] r;
        logic [4:0] e;
        r = $urandom;
        e = 5'($urandom_range(8, 22));
        return {r[15], e, r[9:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sync-read buffers and an ideal fixed-latency multiplier (not reset, on purpose).
    always @(posedge clk) begin
        if (bus.x_ren_o) bus.x_rdata_i <= xmem[bus.x_addr_o];
        if (bus.d_ren_o) bus.d_rdata_i <= dmem[bus.d_addr_o];
        mv    <= {mv[MUL_LAT-2:0], bus.mul_valid_o};
        mr[0] <= fp_mul(bus.mul_a_o, bus.mul_b_o);
        for (int i = 1; i < MUL_LAT; i++) mr[i] <= mr[i-1];
    end
    assign bus.mul_valid_i = mv[MUL_LAT-1];
    assign bus.mul_res_i   = mr[MUL_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_pop = 0;
            exp_iss = 0;
            hold    = 0;
        end else begin
            if (bus.x_ren_o) begin
                check_eq("iss_idx", 32'(bus.x_addr_o), 32'(exp_iss));
                check_eq("d_addr", 32'(bus.d_addr_o), 32'((exp_iss / P) % H));
                check_eq("d_ren", 32'(bus.d_ren_o), 32'd1);
                check_eq("credit", 32'((iss_cnt - pops - int'(bus.y_valid_o & bus.y_ready_i))
                                       < int'(FIFO_DEP)), 32'd1);
                exp_iss = (exp_iss + 1) % N;
                iss_cnt++;
            end
            if (bus.y_valid_o && !first_seen) begin
                first_seen    = 1;
                first_vld_cyc = cyc;
            end
            if (hold) begin
                check_eq("hold_valid", 32'(bus.y_valid_o), 32'd1);
                check_eq("hold_data", 32'(bus.y_data_o), 32'(hold_data));
                check_eq("hold_addr", 32'(bus.y_addr_o), 32'(hold_addr));
            end
            hold      = bus.y_valid_o && !bus.y_ready_i;
            hold_data = bus.y_data_o;
            hold_addr = bus.y_addr_o;
            if (bus.y_valid_o && bus.y_ready_i) begin
                check_eq("y_addr", 32'(bus.y_addr_o), 32'(exp_pop));
                check_eq("y_data", 32'(bus.y_data_o), 32'(exp_y(exp_pop)));
                exp_pop      = (exp_pop + 1) % N;
                pops++;
                last_pop_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                check_eq("done_lat", 32'(cyc - last_pop_cyc), 32'd1);
                check_eq("done_pops", 32'(pops), 32'(N));
                check_eq("busy_at_done", 32'(busy_o), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: ready 30%, 2: 50-cycle stall early in the pass.
    task automatic run_pass(input int mode, input bit extra);
        bit fin;
        pops = 0; iss_cnt = 0; done_cnt = 0; first_seen = 0;
        start_i = 1'b1;
        start_cyc = cyc;
        bus.y_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        fin = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            case (mode)
                0:       bus.y_ready_i = 1'b1;
                1:       bus.y_ready_i = ($urandom_range(0, 99) < 30);
                default: bus.y_ready_i = !(k >= 3 && k < 53);
            endcase
            start_i = extra && busy_o && ($urandom_range(0, 3) == 0);
            tick();
            if (done_cnt != 0) fin = 1;
        end
        start_i = 1'b0;
        bus.y_ready_i = 1'b1;
        if (!fin) check_eq("timeout", 32'd0, 32'd1);
        repeat (5) tick();
        check_eq("first_vld_lat", 32'(first_vld_cyc - start_cyc), 32'd8);
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("total_pops", 32'(pops), 32'(N));
        check_eq("total_issues", 32'(iss_cnt), 32'(N));
        check_eq("idle_busy", 32'(busy_o), 32'd0);
        check_eq("idle_y_valid", 32'(bus.y_valid_o), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_x_ren"}, 32'(bus.x_ren_o), 32'd0);
        check_eq({tag, "_d_ren"}, 32'(bus.d_ren_o), 32'd0);
        check_eq({tag, "_mul_valid"}, 32'(bus.mul_valid_o), 32'd0);
        check_eq({tag, "_y_valid"}, 32'(bus.y_valid_o), 32'd0);
        check_eq({tag, "_x_addr"}, 32'(bus.x_addr_o), 32'd0);
        check_eq({tag, "_d_addr"}, 32'(bus.d_addr_o), 32'd0);
    endtask

    initial begin
        bus.y_ready_i = 1'b1;
        for (int i = 0; i < N; i++) xmem[i] = 16'h3C00;
        for (int i = 0; i < H; i++) dmem[i] = 16'h4000;
        repeat (3) tick();
        check_quiet("rst");
        rst = 1'b0;
        repeat (2) tick();

        run_pass(0, 0);
        check_eq("model_1x2", 32'(exp_y(5)), 32'h4000);
        dmem[1] = 16'hC000;
        check_eq("model_1xm2", 32'(exp_y(6)), 32'hC000);
        run_pass(0, 1);

        for (int i = 0; i < N; i++) xmem[i] = rnd_fp();
        for (int i = 0; i < H; i++) dmem[i] = rnd_fp();
        run_pass(2, 0);
        run_pass(1, 1);

        // Abort mid-pass, then check a clean pass afterwards.
        pops = 0; iss_cnt = 0; done_cnt = 0; first_seen = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("flush_y_valid", 32'(bus.y_valid_o), 32'd0);
            check_eq("flush_busy", 32'(busy_o), 32'd0);
        end
        for (int i = 0; i < N; i++) xmem[i] = rnd_fp();
        run_pass(0, 0);
        run_pass(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
